// File: rtl/uart_work_assembler.sv
// uart_work_assembler
// Receive-side packet assembler for the miner's serial link. Collects a
// 45-byte work packet (32-byte midstate, 12-byte data tail, XOR checksum)
// from the UART receiver and validates it. A good packet updates
// midstate/data with a one-cycle new_work strobe. A bad checksum, an
// inter-byte timeout or a UART framing error discards the partial packet
// with a pkt_error strobe and a sticky err_code.

module uart_work_assembler #(
    parameter int baud_rate     = 9600,
    parameter int sys_clk_freq  = 100000000,
    parameter int timeout_bytes = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         received,
    input  logic [7:0]   rx_byte,
    input  logic         recv_error,
    output logic [255:0] midstate,
    output logic [95:0]  data,
    output logic         new_work,
    output logic         busy,
    output logic         pkt_error,
    output logic [1:0]   err_code
);

    // Inter-byte gap, in clk cycles, after which a partial packet is dropped.
    localparam int timeout_cycles = timeout_bytes * 10 * (sys_clk_freq / baud_rate);
    localparam int timer_width    = $clog2(timeout_cycles + 1);

    localparam logic [timer_width-1:0] timer_load = timer_width'(timeout_cycles);
    localparam logic [timer_width-1:0] timer_one  = timer_width'(1);
    localparam logic [5:0]             last_index = 6'd44;

    localparam logic [1:0] err_checksum = 2'd1;
    localparam logic [1:0] err_timeout  = 2'd2;
    localparam logic [1:0] err_uart     = 2'd3;

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    state_t                 state_q, state_d;
    logic [5:0]             cnt_q, cnt_d;
    logic [7:0]             acc_q, acc_d;
    logic [351:0]           sr_q, sr_d;
    logic [timer_width-1:0] timer_q, timer_d;
    logic [255:0]           midstate_d;
    logic [95:0]            data_d;
    logic                   new_work_d;
    logic                   busy_d;
    logic                   pkt_error_d;
    logic [1:0]             err_code_d;

    // Next-state and datapath: decide what each received byte, gap cycle or
    // UART error does to the packet in progress.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        sr_d        = sr_q;
        timer_d     = timer_q;
        midstate_d  = midstate;
        data_d      = data;
        new_work_d  = 1'b0;
        pkt_error_d = 1'b0;
        err_code_d  = err_code;

        case (state_q)
            IDLE: begin
                // A framing error here has no partial packet to abort; a byte
                // that arrives with it is not trusted and is dropped.
                if (received && !recv_error) begin
                    sr_d    = {sr_q[343:0], rx_byte};
                    acc_d   = rx_byte;
                    cnt_d   = 6'd1;
                    timer_d = timer_load;
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                if (recv_error) begin
                    // Error beats a simultaneous byte: the byte is dropped.
                    pkt_error_d = 1'b1;
                    err_code_d  = err_uart;
                    cnt_d       = 6'd0;
                    timer_d     = '0;
                    state_d     = IDLE;
                end else if (received) begin
                    if (cnt_q == last_index) begin
                        // Checksum byte: it is compared, never shifted in.
                        if (rx_byte == acc_q) begin
                            midstate_d = sr_q[351:96];
                            data_d     = sr_q[95:0];
                            new_work_d = 1'b1;
                        end else begin
                            pkt_error_d = 1'b1;
                            err_code_d  = err_checksum;
                        end
                        cnt_d   = 6'd0;
                        timer_d = '0;
                        state_d = IDLE;
                    end else begin
                        // A byte on the expiry cycle still wins and reloads.
                        sr_d    = {sr_q[343:0], rx_byte};
                        acc_d   = acc_q ^ rx_byte;
                        cnt_d   = cnt_q + 6'd1;
                        timer_d = timer_load;
                    end
                end else if (timer_q <= timer_one) begin
                    // This is the full-length gap cycle: abort now so a byte
                    // on the very next cycle already starts a fresh packet.
                    pkt_error_d = 1'b1;
                    err_code_d  = err_timeout;
                    cnt_d       = 6'd0;
                    timer_d     = '0;
                    state_d     = IDLE;
                end else begin
                    timer_d = timer_q - timer_one;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 6'd0;
                timer_d = '0;
            end
        endcase

        busy_d = (state_d == COLLECT);
    end

    // State register: synchronous reset clears the partial packet and the
    // published work without raising an error.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the values from before this edge.
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 6'd0;
            acc_q     <= 8'd0;
            sr_q      <= '0;
            timer_q   <= '0;
            midstate  <= '0;
            data      <= '0;
            new_work  <= 1'b0;
            busy      <= 1'b0;
            pkt_error <= 1'b0;
            err_code  <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            sr_q      <= sr_d;
            timer_q   <= timer_d;
            midstate  <= midstate_d;
            data      <= data_d;
            new_work  <= new_work_d;
            busy      <= busy_d;
            pkt_error <= pkt_error_d;
            err_code  <= err_code_d;
        end
    end

endmodule

// File: tb/tb_uart_work_assembler.sv
// tb_uart_work_assembler
// Drives byte streams into uart_work_assembler one clock at a time and
// compares every output, every cycle, with a packet-level reference model
// (byte queue plus idle-gap count). Small clock/baud parameters give a
// 160-cycle timeout.

module tb_uart_work_assembler;

    localparam int tb_sys_clk = 160;
    localparam int tb_baud    = 10;
    localparam int tb_tbytes  = 1;
    localparam int gap_limit  = tb_tbytes * 10 * (tb_sys_clk / tb_baud);

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         received = 1'b0;
    logic [7:0]   rx_byte = 8'd0;
    logic         recv_error = 1'b0;
    logic [255:0] midstate;
    logic [95:0]  data;
    logic         new_work;
    logic         busy;
    logic         pkt_error;
    logic [1:0]   err_code;

    uart_work_assembler #(
        .baud_rate    (tb_baud),
        .sys_clk_freq (tb_sys_clk),
        .timeout_bytes(tb_tbytes)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .received  (received),
        .rx_byte   (rx_byte),
        .recv_error(recv_error),
        .midstate  (midstate),
        .data      (data),
        .new_work  (new_work),
        .busy      (busy),
        .pkt_error (pkt_error),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    bit           m_in_pkt;
    logic [7:0]   m_q[$];
    int           m_gap;
    logic [255:0] m_mid;
    logic [95:0]  m_data;
    logic         m_nw;
    logic         m_pe;
    logic         m_busy;
    logic [1:0]   m_ec;

    logic [7:0]   pkt[45];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Apply one cycle of inputs to the model; results are what the outputs
    // must show after the coming clock edge.
    task automatic model_step(input logic r, input logic rcv, input logic [7:0] b, input logic rerr);
        logic [7:0] x;
        m_nw = 1'b0;
        m_pe = 1'b0;
        if (r) begin
            m_in_pkt = 1'b0;
            m_q.delete();
            m_gap  = 0;
            m_mid  = '0;
            m_data = '0;
            m_ec   = 2'd0;
        end else if (m_in_pkt) begin
            if (rerr) begin
                m_pe = 1'b1; m_ec = 2'd3; m_in_pkt = 1'b0; m_q.delete();
            end else if (rcv) begin
                if (m_q.size() == 44) begin
                    x = 8'd0;
                    foreach (m_q[i]) x ^= m_q[i];
                    if (x == b) begin
                        for (int i = 0; i < 32; i++) m_mid[255 - 8*i -: 8] = m_q[i];
                        for (int i = 0; i < 12; i++) m_data[95 - 8*i -: 8] = m_q[32 + i];
                        m_nw = 1'b1;
                    end else begin
                        m_pe = 1'b1; m_ec = 2'd1;
                    end
                    m_in_pkt = 1'b0;
                    m_q.delete();
                end else begin
                    m_q.push_back(b);
                    m_gap = 0;
                end
            end else begin
                m_gap++;
                if (m_gap == gap_limit) begin
                    m_pe = 1'b1; m_ec = 2'd2; m_in_pkt = 1'b0; m_q.delete();
                end
            end
        end else if (rcv && !rerr) begin
            m_q.delete();
            m_q.push_back(b);
            m_in_pkt = 1'b1;
            m_gap    = 0;
        end
        m_busy = m_in_pkt;
    endtask

    // One clock: drive at the falling edge, sample at the next falling edge.
    task automatic tick(input logic r, input logic rcv, input logic [7:0] b, input logic rerr);
        rst        = r;
        received   = rcv;
        rx_byte    = b;
        recv_error = rerr;
        model_step(r, rcv, b, rerr);
        @(posedge clk);
        @(negedge clk);
        rst        = 1'b0;
        received   = 1'b0;
        recv_error = 1'b0;
        check("new_work",  {255'd0, new_work},  {255'd0, m_nw});
        check("pkt_error", {255'd0, pkt_error}, {255'd0, m_pe});
        check("busy",      {255'd0, busy},      {255'd0, m_busy});
        check("err_code",  {254'd0, err_code},  {254'd0, m_ec});
        check("midstate",  midstate,            m_mid);
        check("data",      {160'd0, data},      {160'd0, m_data});
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 1'b0, 8'd0, 1'b0);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        tick(1'b0, 1'b1, b, 1'b0);
    endtask

    // Send pkt[0..43] plus its XOR checksum (optionally corrupted).
    task automatic send_pkt(input int gap, input bit corrupt);
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < 44; i++) begin
            x ^= pkt[i];
            send(pkt[i], gap);
        end
        send(corrupt ? (x ^ 8'h01) : x, gap);
    endtask

    task automatic fill_up(input logic [7:0] base);
        for (int i = 0; i < 44; i++) pkt[i] = base + 8'(i);
    endtask

    task automatic fill_down(input logic [7:0] base);
        for (int i = 0; i < 44; i++) pkt[i] = base - 8'(i);
    endtask

    initial begin
        logic [255:0] mid_up;
        logic [255:0] mid_down;
        logic [95:0]  data_up;
        int           g;
        mid_up   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        mid_down = 256'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0efeeedecebeae9e8e7e6e5e4e3e2e1e0;
        data_up  = 96'h202122232425262728292a2b;

        @(negedge clk);
        // Reset state.
        repeat (3) tick(1'b1, 1'b0, 8'd0, 1'b0);
        idle(2);

        // Bad checksum before any good packet: outputs stay cleared.
        fill_up(8'h00);
        send_pkt(0, 1'b1);
        idle(2);
        check("bad_csum_mid", midstate, 256'd0);
        check("bad_csum_code", {254'd0, err_code}, 256'd1);

        // Good packet 0x00..0x2B, checksum 0x00.
        send_pkt(0, 1'b0);
        idle(2);
        check("good_mid", midstate, mid_up);
        check("good_data", {160'd0, data}, {160'd0, data_up});

        // Timeout: 10 bytes then a full gap.
        for (int i = 0; i < 10; i++) send(pkt[i], 0);
        idle(gap_limit);
        check("timeout_code", {254'd0, err_code}, 256'd2);
        check("timeout_busy", {255'd0, busy}, 256'd0);
        fill_up(8'h40);
        send_pkt(1, 1'b0);
        idle(1);

        // Gap one short of the limit keeps the packet.
        fill_up(8'h80);
        for (int i = 0; i < 10; i++) send(pkt[i], 0);
        idle(gap_limit - 1);
        begin
            logic [7:0] x;
            x = 8'd0;
            for (int i = 0; i < 44; i++) x ^= pkt[i];
            for (int i = 10; i < 44; i++) send(pkt[i], 0);
            send(x, 0);
        end
        idle(1);

        // UART error after byte 20, then a fresh good packet.
        fill_up(8'h00);
        for (int i = 0; i <= 20; i++) send(pkt[i], 0);
        tick(1'b0, 1'b0, 8'd0, 1'b1);
        check("uart_code", {254'd0, err_code}, 256'd3);
        send_pkt(0, 1'b0);
        idle(1);

        // Reset after byte 30: everything clears, next packet is clean.
        for (int i = 0; i <= 30; i++) send(pkt[i], 0);
        tick(1'b1, 1'b0, 8'd0, 1'b0);
        check("rst_mid", midstate, 256'd0);
        check("rst_code", {254'd0, err_code}, 256'd0);
        send_pkt(0, 1'b0);
        idle(1);

        // Back-to-back packets, strobes every 2 cycles.
        fill_up(8'h00);
        send_pkt(1, 1'b0);
        fill_down(8'hff);
        send_pkt(1, 1'b0);
        idle(2);
        check("b2b_mid", midstate, mid_down);

        // Randomized streams: random bytes, gaps (some around the limit),
        // corrupted checksums and UART errors.
        for (int p = 0; p < 30; p++) begin
            logic [7:0] x;
            bit         corrupt;
            x = 8'd0;
            corrupt = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 45; i++) begin
                if (i < 44) begin
                    pkt[i] = 8'($urandom);
                    x ^= pkt[i];
                end
                g = ($urandom_range(0, 24) == 0) ? int'($urandom_range(gap_limit - 3, gap_limit + 2))
                                                 : int'($urandom_range(0, 2));
                idle(g);
                if (m_in_pkt && $urandom_range(0, 79) == 0)
                    tick(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
                if (i < 44) tick(1'b0, 1'b1, pkt[i], 1'b0);
                else        tick(1'b0, 1'b1, corrupt ? (x ^ 8'h5a) : x, 1'b0);
            end
        end
        idle(gap_limit + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_work_assembler.md
# uart_work_assembler

Receive-side packet assembler for the miner's serial link. Sits directly downstream of the UART receiver, consuming its `received`/`rx_byte`/`recv_error` outputs. Collects a 45-byte work packet (32-byte midstate, 12-byte data tail, 1-byte XOR checksum) and validates it. On success it presents `midstate`/`data` to the hashing core with a one-cycle `new_work` strobe; malformed or stalled packets are discarded with an error code.

## Interface
- `baud_rate`, 9600, serial bit rate; must match the UART receiver.
- `sys_clk_freq`, 100000000, clk frequency in Hz.
- `timeout_bytes`, 4, inter-byte gap in byte-times (10 bits each) that aborts a partial packet. Timeout cycles T = timeout_bytes * 10 * (sys_clk_freq / baud_rate), integer division; default T = 416640.
- `clk`  input  1  clock; all logic on rising edge.
- `rst`  input  1  synchronous reset, active-high.
- `received`  input  1  one-cycle strobe; `rx_byte` valid in the same cycle.
- `rx_byte`  input  8  received byte.
- `recv_error`  input  1  one-cycle UART framing-error strobe.
- `midstate`  output  256  last valid midstate; first packet byte in bits [255:248].
- `data`  output  96  last valid data tail; byte 32 in bits [95:88], byte 43 in bits [7:0].
- `new_work`  output  1  one-cycle strobe: `midstate`/`data` just updated.
- `busy`  output  1  high while a packet is partially received.
- `pkt_error`  output  1  one-cycle strobe: packet discarded.
- `err_code`  output  2  cause of the last discard: 1 = checksum, 2 = timeout, 3 = UART error; holds until the next discard.

## Operation
- States: IDLE and COLLECT. Byte counter `cnt` is 0..44 (6 bits). The running XOR `acc` is 8 bits. The shift register `sr` is 352 bits. Timeout counter width is ceil(log2(T+1)).
- IDLE, `received`:
  - `sr <= {sr[343:0], rx_byte}`, `acc <= rx_byte`, `cnt <= 1`.
  - Timer loads T.
  - Go to COLLECT.
- COLLECT, `received`, `cnt` < 44:
  - Shift into `sr`, `acc ^= rx_byte`, `cnt++`.
  - Timer reloads T.
- COLLECT, `received`, `cnt` == 44 (checksum byte):
  - If `rx_byte == acc`: `midstate <= sr[351:96]`, `data <= sr[95:0]`, `new_work <= 1`.
  - Else: `pkt_error <= 1`, `err_code <= 1`; `midstate`/`data` unchanged.
  - In both cases go to IDLE with `cnt <= 0`.
- COLLECT, no `received`:
  - Timer decrements.
  - At 0: `pkt_error`, `err_code <= 2`, go to IDLE.
- `recv_error` in COLLECT: `pkt_error`, `err_code <= 3`, go to IDLE. `recv_error` in IDLE is ignored (no partial packet).
- `busy` = (state == COLLECT), registered.
- No backpressure. The consumer must latch `midstate`/`data` on `new_work` or use them until the next strobe.

## Timing
- Reset values:
  - `midstate` = 0, `data` = 0.
  - `new_work` = 0, `pkt_error` = 0, `busy` = 0, `err_code` = 0.
  - Internally: state IDLE, `cnt` = 0, `acc` = 0, timer = 0.
- Latency: checksum byte strobed in cycle N gives `new_work`, or `pkt_error`, high in cycle N+1 only. New `midstate`/`data` are visible from N+1.
- `busy` rises in the cycle after the first byte's strobe and falls in the cycle the completion or error strobe is high.
- Simultaneous `received` and timer expiry: the byte wins (timer reloads, no timeout).
- Simultaneous `recv_error` and `received`: the error wins and the byte is dropped.
- A byte arriving in the cycle after completion starts a new packet (IDLE handles it normally). Back-to-back packets need no gap.
- `rst` mid-packet:
  - The partial packet is discarded and no error is flagged.
  - `midstate`/`data` are cleared to 0.
  - The next byte after reset release is byte 0.
- Timeout is exact: a gap of T cycles with no strobe after the last strobe aborts; a strobe arriving at or before T−1 cycles of gap keeps the packet.

## Test plan
- Good packet: bytes 0x00..0x2B, checksum 0x00 (their XOR) -> one `new_work` pulse one cycle after the last strobe; `midstate` = 0x000102…1F; `data` = 0x202122…2B; `err_code` stays 0.
- Bad checksum: same 44 bytes, checksum 0x01 -> `pkt_error` pulse, `err_code` = 1, `midstate`/`data` still 0, no `new_work`.
- Timeout with small parameters (sys_clk_freq = 160, baud_rate = 10, timeout_bytes = 1, T = 160): 10 bytes, then 160 idle cycles -> `pkt_error`, `err_code` = 2, `busy` low. Then a full good packet -> `new_work` with correct fields. Repeat with a 159-cycle gap -> no timeout.
- UART error: `recv_error` strobe after byte 20 -> `pkt_error`, `err_code` = 3. The following 45 good bytes are accepted as a fresh packet.
- Reset mid-packet: `rst` after byte 30 -> all outputs 0, no `pkt_error`. A full packet then assembles correctly.
- Back-to-back: two good packets with strobes every 2 cycles, second packet bytes 0xFF..0xD4 with checksum 0x00 -> two `new_work` pulses, final `midstate` = 0xFFFEFD…E0.
